// File: rtl/execute_muldiv_pkg.sv
// Shared types for the execute stage: ALU ops (including the M extension),
// forwarding selects and the iterative multiply/divide state machine.
package execute_muldiv_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_control_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_W   = 2'd1,
        FWD_M   = 2'd2
    } forward_t;

    typedef enum logic {
        ALU_SRC_REG = 1'b0,
        ALU_SRC_IMM = 1'b1
    } alu_src_t;

    typedef enum logic [1:0] {
        JUMP_SRC_PC  = 2'd0,
        JUMP_SRC_REG = 2'd1
    } jump_src_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } muldiv_state_t;

    function automatic logic is_muldiv(input alu_control_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                          ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_div(input alu_control_t op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    // Operand signedness for the M ops (rs1 / rs2 respectively).
    function automatic logic op_signed_a(input alu_control_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    endfunction

    function automatic logic op_signed_b(input alu_control_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    endfunction

endpackage

// File: rtl/execute_muldiv_if.sv
// Decode/control inputs and E-stage outputs of the execute stage.
interface execute_muldiv_if #(
    parameter int XLEN = 32
);
    import execute_muldiv_pkg::*;

    logic [XLEN-1:0] d_rs1_value, d_rs2_value, d_pc, d_imm_ext, d_pc_plus_4;
    logic [4:0]      d_rs1, d_rs2, d_rd;
    logic            d_valid;
    logic [XLEN-1:0] m_alu_result, w_result;
    logic            e_flush, e_hold;
    forward_t        e_forward_a, e_forward_b;
    alu_src_t        e_alu_src;
    alu_control_t    e_alu_control;
    logic            e_invert_cond;
    jump_src_t       e_jump_src;

    logic [4:0]      e_rs1, e_rs2, e_rd;
    logic [XLEN-1:0] e_pc_target;
    logic            e_take_branch;
    logic [XLEN-1:0] e_alu_result, e_write_data, e_pc_plus_4;
    logic            e_valid, e_busy;

    modport master (
        output d_rs1_value, d_rs2_value, d_pc, d_imm_ext, d_pc_plus_4,
               d_rs1, d_rs2, d_rd, d_valid, m_alu_result, w_result,
               e_flush, e_hold, e_forward_a, e_forward_b, e_alu_src,
               e_alu_control, e_invert_cond, e_jump_src,
        input  e_rs1, e_rs2, e_rd, e_pc_target, e_take_branch,
               e_alu_result, e_write_data, e_pc_plus_4, e_valid, e_busy
    );

    modport slave (
        input  d_rs1_value, d_rs2_value, d_pc, d_imm_ext, d_pc_plus_4,
               d_rs1, d_rs2, d_rd, d_valid, m_alu_result, w_result,
               e_flush, e_hold, e_forward_a, e_forward_b, e_alu_src,
               e_alu_control, e_invert_cond, e_jump_src,
        output e_rs1, e_rs2, e_rd, e_pc_target, e_take_branch,
               e_alu_result, e_write_data, e_pc_plus_4, e_valid, e_busy
    );

endinterface

// File: rtl/execute_muldiv_muldiv_iter.sv
// Radix-2 iterative multiply/divide: one shift-add or restoring-divide step
// per cycle on operand magnitudes, signs fixed up on the way out.
module muldiv_iter
    import execute_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  alu_control_t    op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            hold,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_t     state, state_nxt;
    logic [CNT_W-1:0]  count;
    alu_control_t      op_q;
    logic [XLEN-1:0]   acc_hi, acc_lo, opnd, a_orig;
    logic              res_neg, rem_neg, b_zero;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] prod, prod_fix;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return '0 - v;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) state <= MD_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    busy = 1'b1;
                    if (!flush) state_nxt = MD_RUN;
                end
            end
            MD_RUN: begin
                busy = 1'b1;
                if (flush)                     state_nxt = MD_IDLE;
                else if (count == CNT_W'(1))   state_nxt = MD_DONE;
            end
            MD_DONE: begin
                if (flush || !hold) state_nxt = MD_IDLE;
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    assign done = (state == MD_DONE);

    always_comb begin
        a_neg     = op_signed_a(op) && a[XLEN-1];
        b_neg     = op_signed_b(op) && b[XLEN-1];
        a_mag     = a_neg ? negate(a) : a;
        b_mag     = b_neg ? negate(b) : b;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_rem   = div_ge ? XLEN'(div_shift - {1'b0, opnd}) : div_shift[XLEN-1:0];
    end

    // Operands are captured at start; forwarding sources move while E stalls.
    always_ff @(posedge clk) begin
        if (state == MD_IDLE && start) begin
            op_q    <= op;
            count   <= CNT_W'(XLEN);
            a_orig  <= a;
            b_zero  <= (b == '0);
            res_neg <= a_neg ^ b_neg;
            rem_neg <= a_neg;
            acc_hi  <= '0;
            if (is_div(op)) begin
                acc_lo <= a_mag;
                opnd   <= b_mag;
            end else begin
                acc_lo <= b_mag;
                opnd   <= a_mag;
            end
        end else if (state == MD_RUN) begin
            count <= count - 1'b1;
            if (is_div(op_q)) begin
                acc_hi <= div_rem;
                acc_lo <= {acc_lo[XLEN-2:0], div_ge};
            end else begin
                acc_hi <= mul_sum[XLEN:1];
                acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = res_neg ? ('0 - prod) : prod;
        result   = '0;
        case (op_q)
            ALU_MUL:                          result = prod_fix[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:
                result = b_zero ? '1 : (res_neg ? negate(acc_lo) : acc_lo);
            ALU_REM, ALU_REMU:
                result = b_zero ? a_orig : (rem_neg ? negate(acc_hi) : acc_hi);
            default:                          result = '0;
        endcase
    end

endmodule

// File: rtl/execute_muldiv.sv
// Execute stage: D->E register, operand forwarding, ALU, branch target and
// the multi-cycle M-extension unit that stalls the front end via e_busy.
module execute_muldiv
    import execute_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic             clk,
    input logic             reset_n,
    execute_muldiv_if.slave bus
);

    localparam int SH_W = $clog2(XLEN);

    logic [XLEN-1:0] e_rs1_value, e_rs2_value, e_pc, e_imm_ext, e_pc_plus_4;
    logic [4:0]      e_rs1, e_rs2, e_rd;
    logic            e_valid;
    logic [XLEN-1:0] src_a, src_b, write_data, alu_out, md_result;
    logic            md_start, md_busy, md_done;

    function automatic logic [XLEN-1:0] fwd_sel(input forward_t sel,
                                                input logic [XLEN-1:0] reg_v,
                                                input logic [XLEN-1:0] w_v,
                                                input logic [XLEN-1:0] m_v);
        case (sel)
            FWD_REG: return reg_v;
            FWD_W:   return w_v;
            FWD_M:   return m_v;
            default: return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] alu_f(input alu_control_t ctrl,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] a_s;
        logic signed [XLEN-1:0] b_s;
        logic [SH_W-1:0]        sh;
        a_s = a;
        b_s = b;
        sh  = b[SH_W-1:0];
        case (ctrl)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return a_s >>> sh;
            ALU_SLT:  return {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
            default:  return '0;
        endcase
    endfunction

    // D->E boundary: flush beats everything, busy/hold freeze the slot.
    always_ff @(posedge clk) begin
        if (!reset_n || bus.e_flush) begin
            e_rs1_value <= '0;
            e_rs2_value <= '0;
            e_pc        <= '0;
            e_imm_ext   <= '0;
            e_pc_plus_4 <= '0;
            e_rs1       <= '0;
            e_rs2       <= '0;
            e_rd        <= '0;
            e_valid     <= 1'b0;
        end else if (!(md_busy || bus.e_hold)) begin
            e_rs1_value <= bus.d_rs1_value;
            e_rs2_value <= bus.d_rs2_value;
            e_pc        <= bus.d_pc;
            e_imm_ext   <= bus.d_imm_ext;
            e_pc_plus_4 <= bus.d_pc_plus_4;
            e_rs1       <= bus.d_rs1;
            e_rs2       <= bus.d_rs2;
            e_rd        <= bus.d_rd;
            e_valid     <= bus.d_valid;
        end
    end

    always_comb begin
        src_a      = fwd_sel(bus.e_forward_a, e_rs1_value, bus.w_result, bus.m_alu_result);
        write_data = fwd_sel(bus.e_forward_b, e_rs2_value, bus.w_result, bus.m_alu_result);
        src_b      = (bus.e_alu_src == ALU_SRC_IMM) ? e_imm_ext : write_data;
        alu_out    = alu_f(bus.e_alu_control, src_a, src_b);
        md_start   = e_valid && is_muldiv(bus.e_alu_control);
    end

    muldiv_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (md_start),
        .op      (bus.e_alu_control),
        .a       (src_a),
        .b       (src_b),
        .flush   (bus.e_flush),
        .hold    (bus.e_hold),
        .busy    (md_busy),
        .done    (md_done),
        .result  (md_result)
    );

    assign bus.e_alu_result = md_done ? md_result : alu_out;

    always_comb begin
        case (bus.e_jump_src)
            JUMP_SRC_PC:  bus.e_pc_target = e_pc + e_imm_ext;
            JUMP_SRC_REG: bus.e_pc_target = bus.e_alu_result;
            default:      bus.e_pc_target = '0;
        endcase
    end

    // BEQ-style compares run SUB and rely on e_invert_cond to flip "non-zero".
    assign bus.e_take_branch = (alu_out != '0) ^ bus.e_invert_cond;
    assign bus.e_write_data  = write_data;
    assign bus.e_pc_plus_4   = e_pc_plus_4;
    assign bus.e_rs1         = e_rs1;
    assign bus.e_rs2         = e_rs2;
    assign bus.e_rd          = e_rd;
    assign bus.e_valid       = e_valid;
    assign bus.e_busy        = md_busy;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: forwarding/ALU, every M op, flush,
// hold in DONE and reset mid-iteration.
module tb_execute_muldiv;
    import execute_muldiv_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    execute_muldiv_if #(.XLEN(XLEN)) bus ();

    execute_muldiv #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] rs1v, input logic [31:0] rs2v);
        bus.d_rs1_value   = rs1v;
        bus.d_rs2_value   = rs2v;
        bus.d_pc          = 32'h0;
        bus.d_imm_ext     = 32'h0;
        bus.d_pc_plus_4   = 32'h4;
        bus.d_rs1         = 5'd1;
        bus.d_rs2         = 5'd2;
        bus.d_rd          = 5'd10;
        bus.d_valid       = 1'b1;
        bus.e_alu_control = ALU_ADD;
        bus.e_forward_a   = FWD_REG;
        bus.e_forward_b   = FWD_REG;
        bus.e_alu_src     = ALU_SRC_REG;
        bus.e_jump_src    = JUMP_SRC_PC;
        tick();
    endtask

    task automatic run_md(input string tag, input alu_control_t op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int cyc;
        load(a, b);
        bus.e_alu_control = op;
        bus.d_valid       = 1'b0;
        #1;
        cyc = 0;
        while (bus.e_busy && cyc < 200) begin
            cyc++;
            tick();
        end
        check({tag, "_busy_cycles"}, 64'(cyc), 64'd33);
        check(tag, 64'(bus.e_alu_result), 64'(exp));
        tick();
        bus.e_alu_control = ALU_ADD;
        #1;
        check({tag, "_valid_after"}, 64'(bus.e_valid), 64'd0);
    endtask

    initial begin
        int cyc;
        reset_n           = 1'b0;
        bus.d_rs1_value   = '0;
        bus.d_rs2_value   = '0;
        bus.d_pc          = '0;
        bus.d_imm_ext     = '0;
        bus.d_pc_plus_4   = '0;
        bus.d_rs1         = '0;
        bus.d_rs2         = '0;
        bus.d_rd          = '0;
        bus.d_valid       = 1'b0;
        bus.m_alu_result  = '0;
        bus.w_result      = '0;
        bus.e_flush       = 1'b0;
        bus.e_hold        = 1'b0;
        bus.e_forward_a   = FWD_REG;
        bus.e_forward_b   = FWD_REG;
        bus.e_alu_src     = ALU_SRC_REG;
        bus.e_alu_control = ALU_ADD;
        bus.e_invert_cond = 1'b0;
        bus.e_jump_src    = JUMP_SRC_PC;
        tick();
        tick();

        check("rst_valid", 64'(bus.e_valid), 64'd0);
        check("rst_busy", 64'(bus.e_busy), 64'd0);
        check("rst_alu", 64'(bus.e_alu_result), 64'd0);
        check("rst_target", 64'(bus.e_pc_target), 64'd0);
        check("rst_rd", 64'(bus.e_rd), 64'd0);
        check("rst_pc4", 64'(bus.e_pc_plus_4), 64'd0);
        reset_n = 1'b1;

        // Plain ALU path with forwarding.
        bus.d_rs1_value = 32'd99;
        bus.d_rs2_value = 32'd7;
        bus.d_pc        = 32'h100;
        bus.d_imm_ext   = 32'h20;
        bus.d_pc_plus_4 = 32'h104;
        bus.d_rs1       = 5'd1;
        bus.d_rs2       = 5'd2;
        bus.d_rd        = 5'd3;
        bus.d_valid     = 1'b1;
        tick();
        bus.e_forward_a  = FWD_M;
        bus.m_alu_result = 32'd5;
        #1;
        check("add_fwd_m", 64'(bus.e_alu_result), 64'd12);
        check("add_busy", 64'(bus.e_busy), 64'd0);
        check("add_valid", 64'(bus.e_valid), 64'd1);
        check("add_rd", 64'(bus.e_rd), 64'd3);
        check("add_rs2", 64'(bus.e_rs2), 64'd2);
        check("add_target", 64'(bus.e_pc_target), 64'h120);
        check("add_pc4", 64'(bus.e_pc_plus_4), 64'h104);
        check("add_wdata", 64'(bus.e_write_data), 64'd7);
        check("add_branch", 64'(bus.e_take_branch), 64'd1);
        bus.e_forward_b = FWD_W;
        bus.w_result    = 32'd10;
        #1;
        check("add_fwd_w", 64'(bus.e_alu_result), 64'd15);
        check("wdata_fwd_w", 64'(bus.e_write_data), 64'd10);
        bus.e_alu_src = ALU_SRC_IMM;
        #1;
        check("add_imm", 64'(bus.e_alu_result), 64'h25);
        bus.e_jump_src = JUMP_SRC_REG;
        #1;
        check("jump_reg", 64'(bus.e_pc_target), 64'h25);
        bus.e_forward_a   = FWD_REG;
        bus.e_forward_b   = FWD_REG;
        bus.e_alu_src     = ALU_SRC_REG;
        bus.e_jump_src    = JUMP_SRC_PC;
        bus.e_alu_control = ALU_SUB;
        bus.e_invert_cond = 1'b1;
        #1;
        check("sub", 64'(bus.e_alu_result), 64'd92);
        check("sub_branch_inv", 64'(bus.e_take_branch), 64'd0);
        bus.e_invert_cond = 1'b0;
        bus.e_alu_control = ALU_ADD;

        // M ops, one per row.
        run_md("mul",        ALU_MUL,    32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE);
        run_md("mulh",       ALU_MULH,   32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF);
        run_md("mulhsu",     ALU_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF);
        run_md("mulhu",      ALU_MULHU,  32'hFFFFFFFF, 32'd2,        32'h00000001);
        run_md("mulh_min",   ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000);
        run_md("div",        ALU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        run_md("rem",        ALU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        run_md("divu",       ALU_DIVU,   32'd100,      32'd7,        32'd14);
        run_md("remu",       ALU_REMU,   32'd100,      32'd7,        32'd2);
        run_md("divu_zero",  ALU_DIVU,   32'd100,      32'd0,        32'hFFFFFFFF);
        run_md("remu_zero",  ALU_REMU,   32'd100,      32'd0,        32'd100);
        run_md("div_zero",   ALU_DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF);
        run_md("rem_zero",   ALU_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9);
        run_md("rem_ovf",    ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        run_md("div_ovf",    ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);

        // Flush at RUN cycle 10, with a valid instruction waiting in D.
        load(32'd1000, 32'd3);
        bus.e_alu_control = ALU_DIV;
        bus.d_valid       = 1'b0;
        #1;
        repeat (10) tick();
        check("flush_pre_busy", 64'(bus.e_busy), 64'd1);
        bus.e_flush     = 1'b1;
        bus.d_valid     = 1'b1;
        bus.d_rs1_value = 32'd3;
        bus.d_rs2_value = 32'd4;
        tick();
        bus.e_flush = 1'b0;
        #1;
        check("flush_busy", 64'(bus.e_busy), 64'd0);
        check("flush_valid", 64'(bus.e_valid), 64'd0);
        check("flush_alu", 64'(bus.e_alu_result), 64'd0);
        bus.e_alu_control = ALU_ADD;
        tick();
        check("add_after_flush", 64'(bus.e_alu_result), 64'd7);
        check("add_after_flush_valid", 64'(bus.e_valid), 64'd1);
        check("add_after_flush_busy", 64'(bus.e_busy), 64'd0);

        // Hold asserted through RUN (ignored) and for three DONE cycles.
        load(32'd3, 32'd5);
        bus.e_alu_control = ALU_MUL;
        bus.d_valid       = 1'b0;
        bus.e_hold        = 1'b1;
        #1;
        cyc = 0;
        while (bus.e_busy && cyc < 200) begin
            cyc++;
            tick();
        end
        check("hold_busy_cycles", 64'(cyc), 64'd33);
        for (int i = 0; i < 3; i++) begin
            check("hold_result", 64'(bus.e_alu_result), 64'd15);
            check("hold_valid", 64'(bus.e_valid), 64'd1);
            tick();
        end
        bus.e_hold = 1'b0;
        #1;
        check("hold_release_result", 64'(bus.e_alu_result), 64'd15);
        tick();
        bus.e_alu_control = ALU_ADD;
        #1;
        check("hold_after_valid", 64'(bus.e_valid), 64'd0);

        // Reset in the middle of an iteration.
        load(32'd7, 32'd9);
        bus.e_alu_control = ALU_MUL;
        bus.d_valid       = 1'b0;
        #1;
        repeat (5) tick();
        check("rstrun_pre_busy", 64'(bus.e_busy), 64'd1);
        reset_n = 1'b0;
        tick();
        check("rstrun_valid", 64'(bus.e_valid), 64'd0);
        check("rstrun_busy", 64'(bus.e_busy), 64'd0);
        check("rstrun_alu", 64'(bus.e_alu_result), 64'd0);
        check("rstrun_wdata", 64'(bus.e_write_data), 64'd0);
        check("rstrun_target", 64'(bus.e_pc_target), 64'd0);
        check("rstrun_rd", 64'(bus.e_rd), 64'd0);
        check("rstrun_pc4", 64'(bus.e_pc_plus_4), 64'd0);
        reset_n           = 1'b1;
        bus.e_alu_control = ALU_ADD;
        run_md("mul_after_rst", ALU_MUL, 32'd6, 32'd7, 32'd42);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
